frame_loader: RTL
=================

FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 Parameter COL_BITS, default 6, meaning log2 of panel columns (64).
REQ-002 Parameter ROW_BITS, default 5, meaning log2 of rows per RAM bank (32); the panel has 2 banks, 64 rows.
REQ-003 i_clk  in  1  single clock; all logic is on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_pix_valid  in  1  upstream pixel valid.
REQ-006 o_pix_ready  out  1  loader can accept a pixel this cycle.
REQ-007 i_pix_data  in  16  pixel, RGB565 (R[15:11], G[10:5], B[4:0]).
REQ-008 i_pix_sof  in  1  qualifies the pixel as the first of a frame.
REQ-009 o_wr_addr  out  1+ROW_BITS+COL_BITS (12)  {write page, row-in-bank, column}.
REQ-010 o_wr_data  out  16  pixel to write.
REQ-011 o_wr_en_b1  out  1  write strobe, bank 1 (panel rows 0..31).
REQ-012 o_wr_en_b2  out  1  write strobe, bank 2 (panel rows 32..63).
REQ-013 i_frame_done  in  1  one-cycle pulse from the panel driver at the end of a full display scan (all bit planes).
REQ-014 o_disp_page  out  1  page the panel driver reads; it is the MSB of its RAM read address.
REQ-015 o_swap_pending  out  1  a complete frame is waiting for a swap.
REQ-016 o_sof_err  out  1  one-cycle pulse on a frame restart before completion.

Function
REQ-017 A pixel transfer SHALL occur on a clock edge with i_pix_valid=1 and o_pix_ready=1.
REQ-018 State machine SHALL have three states: IDLE (wait for SOF), FILL (accept pixels), WAIT_SWAP (frame complete, wait for display).
REQ-019 o_pix_ready SHALL be 1 in IDLE and FILL and 0 in WAIT_SWAP; it is a decode of the state register only, with no combinational path from i_pix_valid.
REQ-020 In IDLE, a transfer with i_pix_sof=0 SHALL be consumed and discarded, with no write.
REQ-021 In IDLE, a transfer with i_pix_sof=1 SHALL be written as pixel 0, with next state FILL.
REQ-022 Pixel index n (12 bits, 0..4095) SHALL be raster order: row=n[11:6], column=n[5:0].
REQ-023 Rows 0..31 SHALL write bank 1 and rows 32..63 SHALL write bank 2; row-in-bank = row[4:0].
REQ-024 Write address SHALL be {~o_disp_page, row[4:0], column}; the loader never writes the displayed page.
REQ-025 o_wr_addr, o_wr_data and o_wr_en_b* SHALL be registered, asserted exactly one cycle after the transfer edge, with one strobe high for one cycle per pixel.
REQ-026 Strobes SHALL be 0 in cycles without a transfer; o_wr_addr and o_wr_data then hold their last values.
REQ-027 In FILL, the transfer of pixel 4095 SHALL move the state to WAIT_SWAP and set o_swap_pending=1 on the next edge.
REQ-028 In FILL, a transfer with i_pix_sof=1 SHALL restart the frame: the pixel is written as pixel 0 and o_sof_err pulses for one cycle.
REQ-029 Partially written data SHALL NOT be displayed on a restart.
REQ-030 In WAIT_SWAP, i_frame_done=1 SHALL toggle o_disp_page, clear o_swap_pending and return the state to IDLE, all on the same edge.
REQ-031 i_frame_done SHALL be ignored in IDLE and in FILL, including the cycle in which pixel 4095 transfers; the swap waits for the next pulse.
REQ-032 The pixel counter SHALL be 12 bits and SHALL NOT wrap within a frame; reaching 4095 ends FILL.
REQ-033 Upstream stalls (i_pix_valid=0) in FILL SHALL hold the counter and state indefinitely.
REQ-034 Default parameters SHALL be the only configuration required to be verified; widths SHALL derive from the parameters.

Reset
REQ-035 While i_rst_n=0, state SHALL be IDLE, the counter 0, o_disp_page=0, o_swap_pending=0, o_sof_err=0, o_pix_ready=0, o_wr_en_b1=o_wr_en_b2=0, o_wr_addr=0 and o_wr_data=0.
REQ-036 o_pix_ready SHALL rise on the first clock edge after i_rst_n deasserts.
REQ-037 Reset asserted mid-frame or in WAIT_SWAP SHALL abandon the frame immediately, clear any pending write strobe and force o_disp_page=0.

Verification
REQ-038 Reset release, then 4096 pixels (data=n, SOF on n=0) with continuous valid -> 2048 b1 writes at addr 0x800..0xFFF, then 2048 b2 writes at 0x800..0xFFF, with o_swap_pending=1 and ready=0 after the last.
REQ-039 Then an i_frame_done pulse -> o_disp_page=1, pending=0; the next frame writes addresses 0x000..0x7FF.
REQ-040 Three non-SOF pixels in IDLE, then SOF -> three pixels consumed with no strobes; the SOF pixel is written to addr 0x800 on b1.
REQ-041 SOF at pixel 1000 of a frame -> o_sof_err pulses once, that pixel is written at 0x800, the frame completes 4096 transfers later, and o_disp_page is unchanged throughout.
REQ-042 i_frame_done coincident with the pixel 4095 transfer -> no swap; a later pulse swaps.
REQ-043 Random valid gaps, plus i_rst_n asserted at pixel 2000 -> strobes drop asynchronously; after release, pages are 0 and the loader waits in IDLE for SOF.

Source files
------------

// File: rtl/frame_loader_if.sv
// Pixel stream handshake between the upstream pixel source and the frame loader.
// A transfer happens on a rising edge where i_pix_valid and o_pix_ready are both 1.
interface frame_loader_if;
    logic        i_pix_valid;
    logic        o_pix_ready;
    logic [15:0] i_pix_data;
    logic        i_pix_sof;

    // Upstream pixel source
    modport master (
        output i_pix_valid,
        output i_pix_data,
        output i_pix_sof,
        input  o_pix_ready
    );

    // Frame loader
    modport slave (
        input  i_pix_valid,
        input  i_pix_data,
        input  i_pix_sof,
        output o_pix_ready
    );
endinterface

// File: rtl/frame_loader.sv
// Frame loader: writes a raster-ordered RGB565 pixel stream into the
// undisplayed page of a double-buffered, two-bank panel RAM, then waits for
// the panel driver to finish its scan before swapping pages.
module frame_loader #(
    parameter int unsigned COL_BITS = 6,
    parameter int unsigned ROW_BITS = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    frame_loader_if.slave                pix,
    output logic [ROW_BITS+COL_BITS:0]   o_wr_addr,
    output logic [15:0]                  o_wr_data,
    output logic                         o_wr_en_b1,
    output logic                         o_wr_en_b2,
    input  logic                         i_frame_done,
    output logic                         o_disp_page,
    output logic                         o_swap_pending,
    output logic                         o_sof_err
);

    // Pixel index spans both banks: {bank, row-in-bank, column}.
    localparam int unsigned IDX_BITS  = ROW_BITS + 1 + COL_BITS;
    localparam int unsigned BANK_BITS = ROW_BITS + COL_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = '1;
    localparam logic [IDX_BITS-1:0] ONE_IDX  = IDX_BITS'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_BITS-1:0] cnt;
    logic [IDX_BITS-1:0] cnt_nxt;
    logic [IDX_BITS-1:0] wr_idx;
    logic                wr_req;
    logic                restart;
    logic                frame_end;
    logic                swap;
    logic                live_q;
    logic                xfer;

    // Ready is a pure decode of registers; live_q keeps it low until the
    // first edge after reset release.
    assign pix.o_pix_ready = live_q & (state != WAIT_SWAP);
    assign xfer            = pix.i_pix_valid & pix.o_pix_ready;

    // Next-state, counter and write-request decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_idx    = cnt;
        wr_req    = 1'b0;
        restart   = 1'b0;
        frame_end = 1'b0;
        swap      = 1'b0;
        case (state)
            IDLE: begin
                // Non-SOF pixels are consumed and dropped until a frame starts.
                if (xfer && pix.i_pix_sof) begin
                    wr_req    = 1'b1;
                    wr_idx    = '0;
                    cnt_nxt   = ONE_IDX;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    wr_req = 1'b1;
                    if (pix.i_pix_sof) begin
                        // SOF mid-frame restarts in the same back page, so the
                        // displayed page never sees the partial frame.
                        wr_idx  = '0;
                        cnt_nxt = ONE_IDX;
                        restart = 1'b1;
                    end else if (cnt == LAST_IDX) begin
                        cnt_nxt   = '0;
                        frame_end = 1'b1;
                        state_nxt = WAIT_SWAP;
                    end else begin
                        cnt_nxt = cnt + ONE_IDX;
                    end
                end
            end
            WAIT_SWAP: begin
                if (i_frame_done) begin
                    swap      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and pixel counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Marks that at least one edge has passed since reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // Registered RAM write port: bank select from the index MSB, address
    // targets the page not being displayed; address/data hold when idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_en_b1 <= 1'b0;
            o_wr_en_b2 <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
        end else begin
            o_wr_en_b1 <= wr_req & ~wr_idx[IDX_BITS-1];
            o_wr_en_b2 <= wr_req &  wr_idx[IDX_BITS-1];
            if (wr_req) begin
                o_wr_addr <= {~o_disp_page, wr_idx[BANK_BITS-1:0]};
                o_wr_data <= pix.i_pix_data;
            end
        end
    end

    // Page swap bookkeeping and restart error pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_disp_page    <= 1'b0;
            o_swap_pending <= 1'b0;
            o_sof_err      <= 1'b0;
        end else begin
            o_sof_err <= restart;
            if (swap) begin
                o_disp_page    <= ~o_disp_page;
                o_swap_pending <= 1'b0;
            end else if (frame_end) begin
                o_swap_pending <= 1'b1;
            end
        end
    end

endmodule
